// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN line buffer: FSM encoding, default geometry
// and the helpers that derive window counts and counter widths from it.
package cnn_pkg;

    typedef enum logic {
        FILL   = 1'b0,
        STREAM = 1'b1
    } lb_state_e;

    localparam int DEF_KX       = 3;
    localparam int DEF_KY       = 3;
    localparam int DEF_BIT_IN_F = 8;
    localparam int DEF_IMG_W    = 28;
    localparam int DEF_IMG_H    = 28;

    function automatic int windows_per_frame(input int img_w, input int img_h,
                                             input int kx, input int ky);
        return (img_w - kx + 1) * (img_h - ky + 1);
    endfunction

    // Never returns 0 so a range of one or two values still gets a real bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_WINDOWS = windows_per_frame(DEF_IMG_W, DEF_IMG_H, DEF_KX, DEF_KY);
    localparam int DEF_COL_W   = cnt_width(DEF_IMG_W);
    localparam int DEF_ROW_W   = cnt_width(DEF_IMG_H);

endpackage

// File: rtl/cnn_line_buffer_if.sv
// Pixel-in / window-out stream between the pixel source and the line buffer.
interface cnn_line_buffer_if #(
    parameter int KX       = 3,
    parameter int KY       = 3,
    parameter int BIT_IN_F = 8
);
    logic [BIT_IN_F-1:0]       i_pixel;
    logic                      i_pixel_valid;
    logic [BIT_IN_F*KY*KX-1:0] o_window;
    logic                      o_window_valid;
    logic                      o_frame_done;

    modport master (
        output i_pixel, i_pixel_valid,
        input  o_window, o_window_valid, o_frame_done
    );

    modport slave (
        input  i_pixel, i_pixel_valid,
        output o_window, o_window_valid, o_frame_done
    );
endinterface

// File: rtl/cnn_line_mem.sv
// Single-port line memory: combinational read of the old word at addr,
// write of the new word on the same clock edge (write-after-read).
module cnn_line_mem #(
    parameter int DEPTH  = 28,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage arrays carry no reset so they map onto RAM; stale contents
    // are masked by the FILL state of the line buffer.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/cnn_line_buffer.sv
// Streaming KY x KX window generator for a raster-order image: KY-1 line
// memories plus a shifting window register, valid convolution, stride 1.
module cnn_line_buffer
    import cnn_pkg::*;
#(
    parameter int KX       = DEF_KX,
    parameter int KY       = DEF_KY,
    parameter int BIT_IN_F = DEF_BIT_IN_F,
    parameter int IMG_W    = DEF_IMG_W,
    parameter int IMG_H    = DEF_IMG_H
) (
    input  logic         clk,
    input  logic         i_soft_reset,
    cnn_line_buffer_if.slave bus
);
    localparam int WINDOWS = windows_per_frame(IMG_W, IMG_H, KX, KY);
    localparam int COL_W   = cnt_width(IMG_W);
    localparam int ROW_W   = cnt_width(IMG_H);
    localparam int WCNT_W  = cnt_width(WINDOWS);
    localparam int WIN_W   = BIT_IN_F * KY * KX;

    localparam logic [COL_W-1:0]  COL_LAST      = COL_W'(IMG_W - 1);
    localparam logic [COL_W-1:0]  COL_WIN_FIRST = COL_W'(KX - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST      = ROW_W'(IMG_H - 1);
    localparam logic [ROW_W-1:0]  ROW_FILL_LAST = ROW_W'(KY - 2);
    localparam logic [WCNT_W-1:0] WCNT_LAST     = WCNT_W'(WINDOWS - 1);

    lb_state_e            state, state_next;
    logic [COL_W-1:0]     col;
    logic [ROW_W-1:0]     row;
    logic [WCNT_W-1:0]    win_cnt;
    logic                 accept;
    logic                 emit;
    logic                 frame_last;

    logic [BIT_IN_F-1:0]  lm_rd   [KY-1];
    logic [BIT_IN_F-1:0]  lm_wd   [KY-1];
    logic [BIT_IN_F-1:0]  col_in  [KY];
    logic [BIT_IN_F-1:0]  win      [KY][KX];
    logic [BIT_IN_F-1:0]  win_next [KY][KX];
    logic [WIN_W-1:0]     window_flat;

    logic [WIN_W-1:0]     window_q;
    logic                 window_valid_q;
    logic                 frame_done_q;

    assign accept = bus.i_pixel_valid && !i_soft_reset;

    // Line memory ky holds row (current - (KY-1-ky)); each accepted pixel
    // pushes its column one memory further up the chain.
    for (genvar j = 0; j < KY - 1; j++) begin : g_line
        if (j == KY - 2) begin : g_newest
            assign lm_wd[j] = bus.i_pixel;
        end else begin : g_older
            assign lm_wd[j] = lm_rd[j+1];
        end

        cnn_line_mem #(
            .DEPTH  (IMG_W),
            .WIDTH  (BIT_IN_F),
            .ADDR_W (COL_W)
        ) u_line_mem (
            .clk   (clk),
            .we    (accept),
            .addr  (col),
            .wdata (lm_wd[j]),
            .rdata (lm_rd[j])
        );
    end

    // NOTE: every always_comb output gets a value before any branch so no
    // latch can be inferred.
    always_comb begin
        for (int ky = 0; ky < KY - 1; ky++) begin
            col_in[ky] = lm_rd[ky];
        end
        col_in[KY-1] = bus.i_pixel;

        for (int ky = 0; ky < KY; ky++) begin
            for (int kx = 0; kx < KX - 1; kx++) begin
                win_next[ky][kx] = win[ky][kx+1];
            end
            win_next[ky][KX-1] = col_in[ky];
        end

        window_flat = '0;
        for (int ky = 0; ky < KY; ky++) begin
            for (int kx = 0; kx < KX; kx++) begin
                window_flat[(ky*KX + kx)*BIT_IN_F +: BIT_IN_F] = win_next[ky][kx];
            end
        end
    end

    always_comb begin
        state_next = state;
        emit       = 1'b0;
        frame_last = 1'b0;
        if (accept) begin
            unique case (state)
                FILL: begin
                    if (row == ROW_FILL_LAST && col == COL_LAST) begin
                        state_next = STREAM;
                    end
                end
                STREAM: begin
                    emit = (col >= COL_WIN_FIRST);
                    if (row == ROW_LAST && col == COL_LAST) begin
                        state_next = FILL;
                    end
                end
                default: state_next = FILL;
            endcase
        end
        frame_last = emit && (win_cnt == WCNT_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (i_soft_reset) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (i_soft_reset) begin
            col     <= '0;
            row     <= '0;
            win_cnt <= '0;
        end else if (accept) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
            if (emit) begin
                win_cnt <= frame_last ? '0 : win_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_soft_reset) begin
            for (int ky = 0; ky < KY; ky++) begin
                for (int kx = 0; kx < KX; kx++) begin
                    win[ky][kx] <= '0;
                end
            end
            window_q       <= '0;
            window_valid_q <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            if (accept) begin
                win <= win_next;
            end
            // The output copy only moves when a window is issued, so it stays
            // stable through partial columns and input gaps.
            if (emit) begin
                window_q <= window_flat;
            end
            window_valid_q <= emit;
            frame_done_q   <= frame_last;
        end
    end

    assign bus.o_window       = window_q;
    assign bus.o_window_valid = window_valid_q;
    assign bus.o_frame_done   = frame_done_q;

endmodule

// File: tb/tb_cnn_line_buffer.sv
// Self-checking bench for cnn_line_buffer on a 5x5 image with a 3x3 kernel,
// checked against a frame-array reference model.
module tb_cnn_line_buffer;
    localparam int W  = 5;
    localparam int H  = 5;
    localparam int KX = 3;
    localparam int KY = 3;
    localparam int BW = 8;
    localparam int WB = BW * KX * KY;

    logic clk = 1'b0;
    logic i_soft_reset;
    always #5 clk = ~clk;

    cnn_line_buffer_if #(.KX(KX), .KY(KY), .BIT_IN_F(BW)) bus ();

    cnn_line_buffer #(
        .KX(KX), .KY(KY), .BIT_IN_F(BW), .IMG_W(W), .IMG_H(H)
    ) dut (
        .clk          (clk),
        .i_soft_reset (i_soft_reset),
        .bus          (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: pixel grid of the frame in progress plus raster position.
    logic [BW-1:0] frame [H][W];
    int            pos = 0;
    logic [WB-1:0] exp_win = '0;
    logic          exp_v = 1'b0;
    logic          exp_d = 1'b0;

    function automatic logic [WB-1:0] window_at(input int r, input int c);
        logic [WB-1:0] w;
        w = '0;
        for (int ky = 0; ky < KY; ky++)
            for (int kx = 0; kx < KX; kx++)
                w[(ky*KX + kx)*BW +: BW] = frame[r-(KY-1)+ky][c-(KX-1)+kx];
        return w;
    endfunction

    // Window of an index-valued frame (pixel = row*W+col) whose top-left is base.
    function automatic logic [WB-1:0] const_window(input int base);
        logic [WB-1:0] w;
        w = '0;
        for (int ky = 0; ky < KY; ky++)
            for (int kx = 0; kx < KX; kx++)
                w[(ky*KX + kx)*BW +: BW] = BW'(base + ky*W + kx);
        return w;
    endfunction

    // Drive one cycle, then update the model's expectations for that edge.
    task automatic step(input logic v, input logic rst, input logic [BW-1:0] px);
        int r, c;
        @(negedge clk);
        bus.i_pixel_valid = v;
        bus.i_pixel       = px;
        i_soft_reset      = rst;
        @(posedge clk);
        #1;
        exp_v = 1'b0;
        exp_d = 1'b0;
        if (rst) begin
            pos     = 0;
            exp_win = '0;
        end else if (v) begin
            r = pos / W;
            c = pos % W;
            frame[r][c] = px;
            if (r >= KY-1 && c >= KX-1) begin
                exp_v   = 1'b1;
                exp_d   = (r == H-1) && (c == W-1);
                exp_win = window_at(r, c);
            end
            pos = (pos + 1) % (W*H);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'h00);
            checks += 3;
            if (bus.o_window_valid !== 1'b0) begin errors++; $display("FAIL reset valid: got %b want 0", bus.o_window_valid); end
            if (bus.o_frame_done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", bus.o_frame_done); end
            if (bus.o_window !== '0) begin errors++; $display("FAIL reset window: got %h want 0", bus.o_window); end
        end
    endtask

    task automatic test_continuous();
        int first_idx = -1;
        int n_win = 0;
        logic [WB-1:0] first_w = '0;
        logic [WB-1:0] last_w = '0;
        logic last_done = 1'b0;
        for (int i = 0; i < W*H; i++) begin
            step(1'b1, 1'b0, BW'(i));
            checks += 3;
            if (bus.o_window_valid !== exp_v) begin errors++; $display("FAIL cont valid px%0d: got %b want %b", i, bus.o_window_valid, exp_v); end
            if (bus.o_frame_done !== exp_d) begin errors++; $display("FAIL cont done px%0d: got %b want %b", i, bus.o_frame_done, exp_d); end
            if (bus.o_window !== exp_win) begin errors++; $display("FAIL cont window px%0d: got %h want %h", i, bus.o_window, exp_win); end
            if (bus.o_window_valid === 1'b1) begin
                n_win++;
                if (first_idx < 0) begin first_idx = i; first_w = bus.o_window; end
                last_w    = bus.o_window;
                last_done = bus.o_frame_done;
            end
        end
        checks += 5;
        if (n_win != 9) begin errors++; $display("FAIL cont count: got %0d want 9", n_win); end
        if (first_idx != 12) begin errors++; $display("FAIL cont first pixel: got %0d want 12", first_idx); end
        if (first_w !== const_window(0)) begin errors++; $display("FAIL cont first window: got %h want %h", first_w, const_window(0)); end
        if (last_w !== const_window(12)) begin errors++; $display("FAIL cont last window: got %h want %h", last_w, const_window(12)); end
        if (last_done !== 1'b1) begin errors++; $display("FAIL cont last done: got %b want 1", last_done); end
    endtask

    task automatic test_gaps();
        int accepted = 0;
        int n_win = 0;
        int n_done = 0;
        int cycles = 0;
        logic v;
        while (accepted < W*H && cycles < 400) begin
            v = 1'($urandom_range(0, 1));
            step(v, 1'b0, BW'($urandom));
            cycles++;
            if (v) accepted++;
            checks += 3;
            if (bus.o_window_valid !== exp_v) begin errors++; $display("FAIL gap valid cyc%0d: got %b want %b", cycles, bus.o_window_valid, exp_v); end
            if (bus.o_frame_done !== exp_d) begin errors++; $display("FAIL gap done cyc%0d: got %b want %b", cycles, bus.o_frame_done, exp_d); end
            if (bus.o_window !== exp_win) begin errors++; $display("FAIL gap window cyc%0d: got %h want %h", cycles, bus.o_window, exp_win); end
            if (bus.o_window_valid === 1'b1) n_win++;
            if (bus.o_frame_done === 1'b1) n_done++;
        end
        checks += 3;
        if (accepted != W*H) begin errors++; $display("FAIL gap budget: got %0d pixels want %0d", accepted, W*H); end
        if (n_win != 9) begin errors++; $display("FAIL gap count: got %0d want 9", n_win); end
        if (n_done != 1) begin errors++; $display("FAIL gap done count: got %0d want 1", n_done); end
    endtask

    task automatic test_back_to_back();
        int n_win [2] = '{0, 0};
        logic [WB-1:0] first_w2 = '0;
        logic seen2 = 1'b0;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < W*H; i++) begin
                step(1'b1, 1'b0, (f == 0) ? BW'($urandom) : BW'(i));
                checks += 3;
                if (bus.o_window_valid !== exp_v) begin errors++; $display("FAIL b2b valid f%0d px%0d: got %b want %b", f, i, bus.o_window_valid, exp_v); end
                if (bus.o_frame_done !== exp_d) begin errors++; $display("FAIL b2b done f%0d px%0d: got %b want %b", f, i, bus.o_frame_done, exp_d); end
                if (bus.o_window !== exp_win) begin errors++; $display("FAIL b2b window f%0d px%0d: got %h want %h", f, i, bus.o_window, exp_win); end
                if (bus.o_window_valid === 1'b1) begin
                    n_win[f]++;
                    if (f == 1 && !seen2) begin seen2 = 1'b1; first_w2 = bus.o_window; end
                end
            end
        end
        checks += 3;
        if (n_win[0] != 9) begin errors++; $display("FAIL b2b count f0: got %0d want 9", n_win[0]); end
        if (n_win[1] != 9) begin errors++; $display("FAIL b2b count f1: got %0d want 9", n_win[1]); end
        if (first_w2 !== const_window(0)) begin errors++; $display("FAIL b2b first window f1: got %h want %h", first_w2, const_window(0)); end
    endtask

    task automatic test_mid_reset();
        int n_win = 0;
        for (int i = 0; i <= 17; i++) begin
            step(1'b1, 1'b0, BW'(i));
            checks += 2;
            if (bus.o_window_valid !== exp_v) begin errors++; $display("FAIL mid valid px%0d: got %b want %b", i, bus.o_window_valid, exp_v); end
            if (bus.o_window !== exp_win) begin errors++; $display("FAIL mid window px%0d: got %h want %h", i, bus.o_window, exp_win); end
        end
        step(1'b0, 1'b1, 8'h00);
        checks += 3;
        if (bus.o_window_valid !== 1'b0) begin errors++; $display("FAIL mid reset valid: got %b want 0", bus.o_window_valid); end
        if (bus.o_frame_done !== 1'b0) begin errors++; $display("FAIL mid reset done: got %b want 0", bus.o_frame_done); end
        if (bus.o_window !== '0) begin errors++; $display("FAIL mid reset window: got %h want 0", bus.o_window); end
        for (int i = 0; i < W*H; i++) begin
            step(1'b1, 1'b0, BW'(i));
            checks += 3;
            if (bus.o_window_valid !== exp_v) begin errors++; $display("FAIL post valid px%0d: got %b want %b", i, bus.o_window_valid, exp_v); end
            if (bus.o_frame_done !== exp_d) begin errors++; $display("FAIL post done px%0d: got %b want %b", i, bus.o_frame_done, exp_d); end
            if (bus.o_window !== exp_win) begin errors++; $display("FAIL post window px%0d: got %h want %h", i, bus.o_window, exp_win); end
            if (bus.o_window_valid === 1'b1) n_win++;
        end
        checks += 1;
        if (n_win != 9) begin errors++; $display("FAIL post count: got %0d want 9", n_win); end
    endtask

    task automatic test_reset_drop();
        logic [WB-1:0] first_w = '0;
        logic seen = 1'b0;
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, BW'($urandom));
        step(1'b1, 1'b1, 8'hAA);
        checks += 1;
        if (bus.o_window_valid !== 1'b0) begin errors++; $display("FAIL drop reset valid: got %b want 0", bus.o_window_valid); end
        for (int i = 0; i < W*H; i++) begin
            step(1'b1, 1'b0, BW'(i));
            checks += 2;
            if (bus.o_window_valid !== exp_v) begin errors++; $display("FAIL drop valid px%0d: got %b want %b", i, bus.o_window_valid, exp_v); end
            if (bus.o_window !== exp_win) begin errors++; $display("FAIL drop window px%0d: got %h want %h", i, bus.o_window, exp_win); end
            if (bus.o_window_valid === 1'b1 && !seen) begin seen = 1'b1; first_w = bus.o_window; end
        end
        checks += 1;
        if (first_w !== const_window(0)) begin errors++; $display("FAIL drop first window: got %h want %h", first_w, const_window(0)); end
    endtask

    initial begin
        bus.i_pixel       = '0;
        bus.i_pixel_valid = 1'b0;
        i_soft_reset      = 1'b1;
        test_reset();
        test_continuous();
        test_gaps();
        test_back_to_back();
        test_mid_reset();
        test_reset_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
